// File: rtl/mem_ctrl.sv
// Byte-serial memory bus controller arbitrating instruction fetch and load/store.
// Define MEM_CTRL_LS_PRIORITY_EN for fixed load/store priority; default is round-robin.
module mem_ctrl (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic [31:0] if_data,
    output logic        if_done,
    input  logic        ls_req,
    input  logic        ls_wr,
    input  logic [1:0]  ls_size,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic [31:0] ls_rdata,
    output logic        ls_done,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t      state;
    logic [2:0]  len;
    logic [2:0]  idx_i;
    logic [2:0]  idx_c;
    logic        own_ls;
    logic        inflight;
    logic [31:0] base_a;
    logic [31:0] wdata;
    logic [31:0] asm_word;

    logic        if_ok;
    logic        grant_ls;
    logic        grant_if;
    logic        cap;
    logic        flush_hit;
    logic [2:0]  c_nxt;
    logic [2:0]  req_len;
    logic [31:0] asm_cap;
    logic [31:0] asm_out;

`ifndef MEM_CTRL_LS_PRIORITY_EN
    logic        rr_ls;
`endif

    always_comb begin
        if_ok    = if_req && !if_flush;
        grant_ls = 1'b0;
        grant_if = 1'b0;
        if (state == IDLE && rdy_in) begin
`ifdef MEM_CTRL_LS_PRIORITY_EN
            grant_ls = ls_req;
            grant_if = if_ok && !ls_req;
`else
            grant_ls = ls_req && !(if_ok && !rr_ls);
            grant_if = if_ok && !(ls_req && rr_ls);
`endif
        end

        case (ls_size)
            2'd0:    req_len = 3'd1;
            2'd1:    req_len = 3'd2;
            default: req_len = 3'd4;
        endcase

        flush_hit = if_flush && !own_ls && (state == READ || state == DONE);

        // The RAM answers one cycle late, so capture trails issue by one edge.
        cap     = (state == READ) && inflight;
        c_nxt   = idx_c + {2'b00, cap};
        asm_cap = asm_word;
        if (cap)
            asm_cap[8*idx_c[1:0] +: 8] = mem_din;

        case (len)
            3'd1:    asm_out = {24'b0, asm_cap[7:0]};
            3'd2:    asm_out = {16'b0, asm_cap[15:0]};
            default: asm_out = asm_cap;
        endcase
    end

    always_comb begin
        mem_a    = '0;
        mem_dout = '0;
        mem_wr   = 1'b0;
        if ((state == READ || state == WRITE) && idx_i < len) begin
            mem_a = base_a + {29'b0, idx_i};
            if (state == WRITE) begin
                mem_dout = wdata[8*idx_i[1:0] +: 8];
                mem_wr   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (grant_ls || grant_if) begin
            base_a <= grant_ls ? ls_addr : if_addr;
            wdata  <= ls_wdata;
        end
        if (cap)
            asm_word <= asm_cap;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state    <= IDLE;
            len      <= '0;
            idx_i    <= '0;
            idx_c    <= '0;
            own_ls   <= 1'b0;
            inflight <= 1'b0;
            if_data  <= '0;
            ls_rdata <= '0;
            if_done  <= 1'b0;
            ls_done  <= 1'b0;
`ifndef MEM_CTRL_LS_PRIORITY_EN
            rr_ls    <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_ls || grant_if) begin
                        own_ls   <= grant_ls;
                        len      <= grant_ls ? req_len : 3'd4;
                        idx_i    <= '0;
                        idx_c    <= '0;
                        inflight <= 1'b0;
                        state    <= (grant_ls && ls_wr) ? WRITE : READ;
                    end
`ifndef MEM_CTRL_LS_PRIORITY_EN
                    if (rdy_in && ls_req && if_ok)
                        rr_ls <= !rr_ls;
`endif
                end
                READ: begin
                    if (flush_hit) begin
                        state    <= IDLE;
                        inflight <= 1'b0;
                    end else begin
                        idx_c <= c_nxt;
                        // While paused the host drives the bus: rewind issue to capture.
                        if (!rdy_in) begin
                            idx_i    <= c_nxt;
                            inflight <= 1'b0;
                        end else if (c_nxt == len) begin
                            state    <= DONE;
                            inflight <= 1'b0;
                            if (own_ls) begin
                                ls_done  <= 1'b1;
                                ls_rdata <= asm_out;
                            end else begin
                                if_done  <= 1'b1;
                                if_data  <= asm_out;
                            end
                        end else if (idx_i < len) begin
                            idx_i    <= idx_i + 3'd1;
                            inflight <= 1'b1;
                        end else begin
                            inflight <= 1'b0;
                        end
                    end
                end
                WRITE: begin
                    if (rdy_in) begin
                        idx_i <= idx_i + 3'd1;
                        if (idx_i + 3'd1 == len) begin
                            state   <= DONE;
                            ls_done <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (flush_hit || rdy_in) begin
                        state   <= IDLE;
                        if_done <= 1'b0;
                        ls_done <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a byte-wide RAM model answering one cycle late.
module tb_mem_ctrl;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic [31:0] if_data;
    logic        if_done;
    logic        ls_req;
    logic        ls_wr;
    logic [1:0]  ls_size;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [31:0] ls_rdata;
    logic        ls_done;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    logic [7:0]  ram [0:65535];
    logic        pl_we;
    logic [15:0] pl_a;
    logic [7:0]  pl_d;

    int n_tests;
    int n_fail;

    mem_ctrl dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .rdy_in   (rdy_in),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_flush (if_flush),
        .if_data  (if_data),
        .if_done  (if_done),
        .ls_req   (ls_req),
        .ls_wr    (ls_wr),
        .ls_size  (ls_size),
        .ls_addr  (ls_addr),
        .ls_wdata (ls_wdata),
        .ls_rdata (ls_rdata),
        .ls_done  (ls_done),
        .mem_din  (mem_din),
        .mem_dout (mem_dout),
        .mem_a    (mem_a),
        .mem_wr   (mem_wr)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) begin
        mem_din <= ram[mem_a[15:0]];
        if (mem_wr && rdy_in)
            ram[mem_a[15:0]] <= mem_dout;
        else if (pl_we)
            ram[pl_a] <= pl_d;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        pl_a  = a;
        pl_d  = d;
        pl_we = 1'b1;
        step();
        pl_we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] exp_fetch [0:3];
        logic [2:0]  arb_ls_exp;
        int          waited;

        n_tests  = 0;
        n_fail   = 0;
        rst_in   = 1'b1;
        rdy_in   = 1'b1;
        if_req   = 1'b0;
        if_addr  = '0;
        if_flush = 1'b0;
        ls_req   = 1'b0;
        ls_wr    = 1'b0;
        ls_size  = 2'd0;
        ls_addr  = '0;
        ls_wdata = '0;
        pl_we    = 1'b0;
        pl_a     = '0;
        pl_d     = '0;

        preload(16'h1000, 8'h13);
        preload(16'h1001, 8'h05);
        preload(16'h1002, 8'h00);
        preload(16'h1003, 8'h00);
        preload(16'h2004, 8'h5A);
        preload(16'h3000, 8'h11);
        preload(16'h3001, 8'h22);
        preload(16'h3002, 8'h33);
        preload(16'h3003, 8'h44);

        rst_in = 1'b0;
        check("rst_if_data", if_data, 32'h0);
        check("rst_ls_rdata", ls_rdata, 32'h0);
        check("rst_if_done", {31'b0, if_done}, 32'h0);
        check("rst_ls_done", {31'b0, ls_done}, 32'h0);
        check("rst_mem_a", mem_a, 32'h0);
        check("rst_mem_dout", {24'b0, mem_dout}, 32'h0);
        check("rst_mem_wr", {31'b0, mem_wr}, 32'h0);

        // Reset in the middle of a word read
        ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'd2; ls_addr = 32'h3000;
        step();
        check("midrst_c1_a", mem_a, 32'h3000);
        step();
        step();
        check("midrst_c3_a", mem_a, 32'h3002);
        rst_in = 1'b1;
        #1;
        check("midrst_async_a", mem_a, 32'h0);
        check("midrst_async_wr", {31'b0, mem_wr}, 32'h0);
        check("midrst_async_done", {30'b0, if_done, ls_done}, 32'h0);
        ls_req = 1'b0;
        step();
        rst_in = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            check("postrst_a", mem_a, 32'h0);
            check("postrst_done", {30'b0, if_done, ls_done}, 32'h0);
        end

        // Word fetch
        exp_fetch[0] = 32'h1000; exp_fetch[1] = 32'h1001;
        exp_fetch[2] = 32'h1002; exp_fetch[3] = 32'h1003;
        if_req = 1'b1; if_addr = 32'h1000;
        for (int k = 1; k <= 4; k++) begin
            step();
            check($sformatf("fetch_c%0d_a", k), mem_a, exp_fetch[k-1]);
            check($sformatf("fetch_c%0d_wr", k), {31'b0, mem_wr}, 32'h0);
            check($sformatf("fetch_c%0d_done", k), {31'b0, if_done}, 32'h0);
        end
        step();
        check("fetch_c5_a", mem_a, 32'h0);
        check("fetch_c5_done", {31'b0, if_done}, 32'h0);
        step();
        check("fetch_c6_done", {31'b0, if_done}, 32'h1);
        check("fetch_c6_data", if_data, 32'h00000513);
        if_req = 1'b0;
        step();
        check("fetch_c7_done", {31'b0, if_done}, 32'h0);
        step();

        // Half-word store
        ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'd1; ls_addr = 32'h2002; ls_wdata = 32'h0000BEEF;
        step();
        check("sth_c1_a", mem_a, 32'h2002);
        check("sth_c1_d", {24'b0, mem_dout}, 32'hEF);
        check("sth_c1_wr", {31'b0, mem_wr}, 32'h1);
        check("sth_c1_done", {31'b0, ls_done}, 32'h0);
        step();
        check("sth_c2_a", mem_a, 32'h2003);
        check("sth_c2_d", {24'b0, mem_dout}, 32'hBE);
        check("sth_c2_wr", {31'b0, mem_wr}, 32'h1);
        check("sth_c2_done", {31'b0, ls_done}, 32'h0);
        step();
        check("sth_c3_done", {31'b0, ls_done}, 32'h1);
        check("sth_c3_wr", {31'b0, mem_wr}, 32'h0);
        ls_req = 1'b0; ls_wr = 1'b0;
        step();
        check("sth_c4_done", {31'b0, ls_done}, 32'h0);
        check("sth_ram_2002", {24'b0, ram[16'h2002]}, 32'hEF);
        check("sth_ram_2003", {24'b0, ram[16'h2003]}, 32'hBE);
        check("sth_ram_2004", {24'b0, ram[16'h2004]}, 32'h5A);
        step();

        // Word load with a two-cycle pause
        ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'd2; ls_addr = 32'h3000;
        step();
        check("pause_c1_a", mem_a, 32'h3000);
        step();
        check("pause_c2_a", mem_a, 32'h3001);
        step();
        rdy_in = 1'b0;
        step();
        step();
        rdy_in = 1'b1;
        check("pause_c5_a", mem_a, 32'h3002);
        step();
        check("pause_c6_a", mem_a, 32'h3003);
        step();
        check("pause_c7_done", {31'b0, ls_done}, 32'h0);
        step();
        check("pause_c8_done", {31'b0, ls_done}, 32'h1);
        check("pause_c8_data", ls_rdata, 32'h44332211);
        ls_req = 1'b0;
        step();
        step();

        // Both ports requesting for three accesses
`ifdef MEM_CTRL_LS_PRIORITY_EN
        arb_ls_exp = 3'b111;
`else
        arb_ls_exp = 3'b101;
`endif
        ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'd0; ls_addr = 32'h4000; ls_wdata = 32'h77;
        if_req = 1'b1; if_addr = 32'h1000;
        for (int k = 0; k < 3; k++) begin
            waited = 0;
            step();
            while (!(if_done || ls_done) && waited < 20) begin
                step();
                waited++;
            end
            check($sformatf("arb%0d_seen", k), {31'b0, if_done | ls_done}, 32'h1);
            check($sformatf("arb%0d_ls", k), {31'b0, ls_done}, {31'b0, arb_ls_exp[k]});
            if (k == 2) begin
                ls_req = 1'b0; if_req = 1'b0; ls_wr = 1'b0;
            end
        end
        step();
        step();

        // Flush a fetch with a byte load waiting
        if_req = 1'b1; if_addr = 32'h1000;
        ls_wr = 1'b0; ls_size = 2'd0; ls_addr = 32'h3001;
        step();
        ls_req = 1'b1;
        step();
        step();
        check("flush_c3_a", mem_a, 32'h1002);
        if_flush = 1'b1; if_req = 1'b0;
        step();
        if_flush = 1'b0;
        check("flush_c4_a", mem_a, 32'h0);
        check("flush_c4_ifd", {31'b0, if_done}, 32'h0);
        step();
        check("flush_c5_a", mem_a, 32'h3001);
        check("flush_c5_ifd", {31'b0, if_done}, 32'h0);
        step();
        check("flush_c6_lsd", {31'b0, ls_done}, 32'h0);
        check("flush_c6_ifd", {31'b0, if_done}, 32'h0);
        step();
        check("flush_c7_lsd", {31'b0, ls_done}, 32'h1);
        check("flush_c7_data", ls_rdata, 32'h00000022);
        check("flush_c7_ifd", {31'b0, if_done}, 32'h0);
        ls_req = 1'b0;
        step();
        check("flush_c8_done", {30'b0, if_done, ls_done}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
